// File: rtl/inst_issue_encoder.sv
// Instruction issue encoder: queues compact op requests as 32-bit words, presents the
// head word to the decoder and returns (word, sigs_valid) pairs through a response slot.
module inst_issue_encoder #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_req_valid,
    output logic             io_req_ready,
    input  logic [1:0]       io_req_op,
    input  logic [XLEN-1:0]  io_req_raw,
    output logic [XLEN-1:0]  io_inst,
    input  logic             io_sigs_valid,
    output logic             io_resp_valid,
    input  logic             io_resp_ready,
    output logic [XLEN-1:0]  io_resp_inst,
    output logic             io_resp_sigs_valid,
    output logic [CNT_W-1:0] io_ok_count,
    output logic [CNT_W-1:0] io_bad_count,
    output logic             io_busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             resp_valid_reg;
    logic             resp_sigs_reg;
    logic [XLEN-1:0]  resp_inst_reg;
    logic [CNT_W-1:0] stat_reg [2];
    logic [1:0]       stat_inc;

    logic [XLEN-1:0]  enc_word;
    logic             fifo_empty;
    logic             push;
    logic             issue;

    always_comb begin
        enc_word = io_req_raw;
        case (io_req_op)
            2'd0:    enc_word = XLEN'(32'h0000_257b);
            2'd1:    enc_word = XLEN'(32'h0000_277b);
            default: enc_word = io_req_raw;
        endcase
    end

    assign fifo_empty   = (count_reg == '0);
    assign io_req_ready = (count_reg < FULL_CNT);
    assign push         = io_req_valid && io_req_ready;
    assign issue        = !fifo_empty && (!resp_valid_reg || io_resp_ready);

    // Head word goes straight to the decoder; the decoder's verdict is sampled on issue.
    assign io_inst = fifo_empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= enc_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (issue) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !issue) begin
                count_reg <= count_reg + 1'b1;
            end else if (issue && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_reg <= 1'b0;
            resp_inst_reg  <= '0;
            resp_sigs_reg  <= 1'b0;
        end else if (issue) begin
            resp_valid_reg <= 1'b1;
            resp_inst_reg  <= mem[rd_ptr_reg];
            resp_sigs_reg  <= io_sigs_valid;
        end else if (resp_valid_reg && io_resp_ready) begin
            resp_valid_reg <= 1'b0;
        end
    end

    // Index 0 counts decodable words, index 1 undecodable ones; both saturate.
    assign stat_inc[0] = issue && io_sigs_valid;
    assign stat_inc[1] = issue && !io_sigs_valid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    stat_reg[gi] <= '0;
                end else if (stat_inc[gi] && (stat_reg[gi] != '1)) begin
                    stat_reg[gi] <= stat_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign io_resp_valid      = resp_valid_reg;
    assign io_resp_inst       = resp_inst_reg;
    assign io_resp_sigs_valid = resp_sigs_reg;
    assign io_ok_count        = stat_reg[0];
    assign io_bad_count       = stat_reg[1];
    assign io_busy            = !fifo_empty || resp_valid_reg;
endmodule

// File: tb/tb_inst_issue_encoder.sv
// Self-checking bench for inst_issue_encoder: scoreboarded responses plus per-scenario checks.
module tb_inst_issue_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_raw = '0;
    logic        resp_ready = 1'b1;
    logic        sigs_valid;
    int          sig_mode = 0;

    logic        req_ready, resp_valid, resp_sigs, busy;
    logic [31:0] inst, resp_inst;
    logic [7:0]  ok_cnt, bad_cnt;

    logic        s_req_ready, s_resp_valid, s_resp_sigs, s_busy;
    logic [31:0] s_inst, s_resp_inst;
    logic [1:0]  s_ok_cnt, s_bad_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] word;
        logic        sig;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Decoder stand-in: mode 0 rejects all, 1 accepts all, 2 rejects only 32'hdeadbeef.
    function automatic logic decode_ok(input logic [31:0] w);
        if (sig_mode == 0) return 1'b0;
        if (sig_mode == 1) return 1'b1;
        return (w != 32'hdeadbeef);
    endfunction

    function automatic logic [31:0] encode(input logic [1:0] op, input logic [31:0] raw);
        if (op == 2'd0) return 32'h0000257b;
        if (op == 2'd1) return 32'h0000277b;
        return raw;
    endfunction

    always_comb sigs_valid = decode_ok(inst);

    inst_issue_encoder #(.DEPTH(4), .XLEN(32), .CNT_W(8)) dut (
        .clk(clk), .reset(rst_n),
        .io_req_valid(req_valid), .io_req_ready(req_ready),
        .io_req_op(req_op), .io_req_raw(req_raw),
        .io_inst(inst), .io_sigs_valid(sigs_valid),
        .io_resp_valid(resp_valid), .io_resp_ready(resp_ready),
        .io_resp_inst(resp_inst), .io_resp_sigs_valid(resp_sigs),
        .io_ok_count(ok_cnt), .io_bad_count(bad_cnt), .io_busy(busy)
    );

    inst_issue_encoder #(.DEPTH(4), .XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(rst_n),
        .io_req_valid(req_valid), .io_req_ready(s_req_ready),
        .io_req_op(req_op), .io_req_raw(req_raw),
        .io_inst(s_inst), .io_sigs_valid(sigs_valid),
        .io_resp_valid(s_resp_valid), .io_resp_ready(resp_ready),
        .io_resp_inst(s_resp_inst), .io_resp_sigs_valid(s_resp_sigs),
        .io_ok_count(s_ok_cnt), .io_bad_count(s_bad_cnt), .io_busy(s_busy)
    );

    // Scoreboard: check the consumed response first, then record any accepted request.
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid && resp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected got %h/%0b expected none", resp_inst, resp_sigs);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({resp_inst, resp_sigs} !== {e.word, e.sig}) begin
                        errors++;
                        $display("FAIL resp_order got %h/%0b expected %h/%0b",
                                 resp_inst, resp_sigs, e.word, e.sig);
                    end else begin
                        $display("resp %h sigs_valid=%0b ok", resp_inst, resp_sigs);
                    end
                end
            end
            if (req_valid && req_ready) begin
                exp_t n;
                n.word = encode(req_op, req_raw);
                n.sig  = decode_ok(n.word);
                sb.push_back(n);
                $display("push op=%0d word=%h", req_op, n.word);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        req_valid = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Presents one request and returns 1 time unit after the edge that accepted it.
    task automatic send(input logic [1:0] op, input logic [31:0] raw);
        int waited = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_raw   = raw;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got req_ready=0 expected 1");
        end
        tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({req_ready, inst, resp_valid, ok_cnt, bad_cnt, busy} !== {1'b1, 32'h0, 1'b0, 8'h0, 8'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%0b inst=%h rv=%0b ok=%0d bad=%0d busy=%0b expected 1/0/0/0/0/0",
                     req_ready, inst, resp_valid, ok_cnt, bad_cnt, busy);
        end else $display("reset state ok");
    endtask

    task automatic test_single_push();
        sig_mode   = 0;
        resp_ready = 1'b1;
        send(2'd0, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({inst, busy, resp_valid} !== {32'h257b, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_inst got inst=%h busy=%0b rv=%0b expected 0000257b/1/0", inst, busy, resp_valid);
        end else $display("single: io_inst=%h", inst);
        tick();
        checks++;
        if ({resp_valid, resp_inst, resp_sigs, bad_cnt, ok_cnt} !== {1'b1, 32'h257b, 1'b0, 8'd1, 8'd0}) begin
            errors++;
            $display("FAIL single_resp got rv=%0b %h/%0b bad=%0d ok=%0d expected 1 0000257b/0 bad=1 ok=0",
                     resp_valid, resp_inst, resp_sigs, bad_cnt, ok_cnt);
        end else $display("single: resp %h/%0b bad=%0d", resp_inst, resp_sigs, bad_cnt);
        tick();
        checks++;
        if ({resp_valid, resp_inst, busy} !== {1'b0, 32'h257b, 1'b0}) begin
            errors++;
            $display("FAIL single_drain got rv=%0b inst=%h busy=%0b expected 0/0000257b/0", resp_valid, resp_inst, busy);
        end else $display("single: drained");
    endtask

    task automatic test_back_to_back();
        sig_mode   = 2;
        resp_ready = 1'b1;
        send(2'd1, 32'h0);
        send(2'd2, 32'hdeadbeef);
        checks++;
        if ({resp_valid, resp_inst, resp_sigs} !== {1'b1, 32'h277b, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first got %0b %h/%0b expected 1 0000277b/1", resp_valid, resp_inst, resp_sigs);
        end else $display("b2b: resp0 %h/%0b", resp_inst, resp_sigs);
        send(2'd0, 32'h0);
        req_valid = 1'b0;
        checks++;
        if ({resp_valid, resp_inst, resp_sigs} !== {1'b1, 32'hdeadbeef, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second got %0b %h/%0b expected 1 deadbeef/0", resp_valid, resp_inst, resp_sigs);
        end else $display("b2b: resp1 %h/%0b", resp_inst, resp_sigs);
        tick();
        checks++;
        if ({resp_valid, resp_inst, resp_sigs} !== {1'b1, 32'h257b, 1'b1}) begin
            errors++;
            $display("FAIL b2b_third got %0b %h/%0b expected 1 0000257b/1", resp_valid, resp_inst, resp_sigs);
        end else $display("b2b: resp2 %h/%0b", resp_inst, resp_sigs);
        tick();
        checks++;
        if ({resp_valid, ok_cnt, bad_cnt} !== {1'b0, 8'd2, 8'd1}) begin
            errors++;
            $display("FAIL b2b_counts got rv=%0b ok=%0d bad=%0d expected 0/2/1", resp_valid, ok_cnt, bad_cnt);
        end else $display("b2b: ok=%0d bad=%0d", ok_cnt, bad_cnt);
    endtask

    task automatic test_backpressure();
        sig_mode   = 1;
        resp_ready = 1'b0;
        send(2'd0, 32'h0);
        send(2'd1, 32'h0);
        send(2'd2, 32'h11112222);
        send(2'd3, 32'h33334444);
        send(2'd2, 32'h55556666);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_inst, inst, busy} !== {1'b0, 1'b1, 32'h257b, 32'h277b, 1'b1}) begin
            errors++;
            $display("FAIL bp_full got rdy=%0b rv=%0b resp=%h inst=%h busy=%0b expected 0/1/0000257b/0000277b/1",
                     req_ready, resp_valid, resp_inst, inst, busy);
        end else $display("bp: full, head %h held", inst);
        tick();
        tick();
        checks++;
        if ({req_ready, resp_inst, inst, ok_cnt} !== {1'b0, 32'h257b, 32'h277b, 8'd1}) begin
            errors++;
            $display("FAIL bp_stall got rdy=%0b resp=%h inst=%h ok=%0d expected 0/0000257b/0000277b/1",
                     req_ready, resp_inst, inst, ok_cnt);
        end else $display("bp: stalled");
        resp_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if ({req_ready, resp_valid, busy, ok_cnt, sb.size()} !== {1'b1, 1'b0, 1'b0, 8'd5, 32'd0}) begin
            errors++;
            $display("FAIL bp_release got rdy=%0b rv=%0b busy=%0b ok=%0d left=%0d expected 1/0/0/5/0",
                     req_ready, resp_valid, busy, ok_cnt, sb.size());
        end else $display("bp: released, ok=%0d", ok_cnt);
    endtask

    task automatic test_async_reset();
        sig_mode   = 1;
        resp_ready = 1'b0;
        send(2'd0, 32'h0);
        send(2'd1, 32'h0);
        send(2'd2, 32'haaaa5555);
        send(2'd0, 32'h0);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({req_ready, inst, resp_valid, resp_inst, resp_sigs, busy, ok_cnt, bad_cnt}
            !== {1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 8'h0}) begin
            errors++;
            $display("FAIL async_reset got rdy=%0b inst=%h rv=%0b resp=%h/%0b busy=%0b ok=%0d bad=%0d expected 1/0/0/0/0/0/0/0",
                     req_ready, inst, resp_valid, resp_inst, resp_sigs, busy, ok_cnt, bad_cnt);
        end else $display("async reset: outputs cleared before edge");
        tick();
        tick();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        test_single_push();
    endtask

    task automatic test_saturation();
        sig_mode   = 1;
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(2'd1, 32'h0);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({s_ok_cnt, s_bad_cnt, ok_cnt, s_busy} !== {2'd3, 2'd0, 8'd5, 1'b0}) begin
            errors++;
            $display("FAIL saturate got sat_ok=%0d sat_bad=%0d ok=%0d sat_busy=%0b expected 3/0/5/0",
                     s_ok_cnt, s_bad_cnt, ok_cnt, s_busy);
        end else $display("saturation: sat_ok=%0d ok=%0d", s_ok_cnt, ok_cnt);
    endtask

    initial begin
        apply_reset();
        test_reset();
        apply_reset();
        test_single_push();
        apply_reset();
        test_back_to_back();
        apply_reset();
        test_backpressure();
        apply_reset();
        test_async_reset();
        apply_reset();
        test_saturation();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
